bus_port_endpoint: RTL and testbench
====================================

# bus_port_endpoint

Terminal-side endpoint for one port of the `bs_gnrtr_n_rbtr` bus. It presents a transmit FIFO to the bus on the `pndng`/`pop`/`D_pop` side that the bus pops, and it absorbs packets the bus pushes on the `push`/`D_push` side into a receive FIFO. It filters received packets by destination ID and gives the local host simple valid/ready access to both FIFOs. One instance sits at each of the `drvrs` bus ports, in place of the behavioural FIFO model the bench drivers emulate.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits; must be ≥ 9.
- `depth`, 8: entries per FIFO; power of two, ≥ 2.
- `id`, 0: this port's 8-bit destination ID.
- `broadcast`, 8'hFF: destination ID that is accepted by every port.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pndng` out 1: transmit FIFO is non-empty.
- `D_pop` out `pckg_sz`: head of the transmit FIFO; 0 when `pndng`=0.
- `pop` in 1: the bus consumes the transmit FIFO head.
- `push` in 1: the bus delivers a packet.
- `D_push` in `pckg_sz`: delivered packet.
- `tx_valid` in 1: host write request.
- `tx_data` in `pckg_sz`: host packet, with the destination ID in bits [pckg_sz-1 -: 8].
- `tx_ready` out 1: the transmit FIFO can accept a packet.
- `rx_valid` out 1: the receive FIFO is non-empty.
- `rx_data` out `pckg_sz`: head of the receive FIFO; 0 when `rx_valid`=0.
- `rx_ready` in 1: the host consumes the receive FIFO head.
- `rx_drop` out 1: one-cycle pulse when a pushed packet is discarded.
- `rx_ovf_cnt` out 16: saturating overflow counter; exists only when `BUS_PORT_OVF_CNT_EN` is defined.

## Operation
- Each FIFO uses a circular buffer with read and write pointers of $clog2(depth) bits that wrap modulo `depth`. Each has an occupancy counter of $clog2(depth)+1 bits. Storage is not reset.
- Transmit FIFO:
  - `tx_ready` = (count != depth).
  - A write occurs when `tx_valid & tx_ready`.
  - A read occurs when `pop & pndng`. `pop` while empty is ignored and produces no underflow.
  - A write and a read in the same cycle leave the count unchanged.
  - When the FIFO is full, a write is refused even if `pop` is asserted in the same cycle, because `tx_ready` depends only on occupancy.
- Receive path:
  - The bus has no backpressure, so every `push` is evaluated in the cycle it occurs.
  - A packet is accepted when its destination field `D_push[pckg_sz-1 -: 8]` equals `id` or `broadcast`, and the FIFO is not full or `rx_ready & rx_valid` is asserted in the same cycle.
  - A packet is dropped when its destination mismatches or the FIFO is full with no host read in that cycle.
  - On a drop, `rx_drop` pulses high for one cycle and the FIFO contents are untouched.
- Receive FIFO reads occur on `rx_ready & rx_valid`. `rx_ready` while empty is ignored.
- Reset mid-operation: all queued packets in both FIFOs are discarded. On the following cycle all outputs show their reset values regardless of the `tx_valid`/`push` values present during reset.

## Timing
- Reset values: `pndng`=0, `D_pop`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_drop`=0, `rx_ovf_cnt`=0.
- Inputs `tx_valid`, `pop`, `push` and `rx_ready` are ignored while `reset`=1.
- Transmit latency: a write at edge N makes `pndng`=1 and `D_pop`=packet visible after edge N. An empty-to-empty round trip (write, then pop) takes 1 cycle per stage.
- `pop` at edge N advances `D_pop` to the next entry, or to 0, after edge N.
- Receive latency: an accepted `push` at edge N makes `rx_valid`=1 after edge N. `rx_drop` for a push at edge N is high for the cycle after edge N.
- `D_pop` and `rx_data` are combinational from the head entry and the occupancy counter. There is no combinational path from any input to any output.
- Back-to-back pushes are accepted every cycle. Full throughput is one packet per cycle in each direction.

## Configuration
- `BUS_PORT_OVF_CNT_EN` defined: `rx_ovf_cnt` increments by 1 on each drop caused by a full receive FIFO. Destination-mismatch drops are not counted. The counter saturates at 16'hFFFF and clears only on `reset`.
- `BUS_PORT_OVF_CNT_EN` undefined: the `rx_ovf_cnt` port and its logic are absent. `rx_drop` behaviour is unchanged.

## Test plan
- Transmit fill: with `pckg_sz`=16 and `depth`=8, reset, then write 8 packets 16'h0101..16'h0108 with `pop`=0.
  - Required: `tx_ready`=0 after the 8th write, a 9th write is refused, and `D_pop`=16'h0101.
  - Then pop 8 times: packets appear in order and `pndng`=0 at the end.
- Simultaneous transmit events:
  - FIFO at count 3 with write and pop in the same cycle: count stays 3 and order is preserved.
  - FIFO full with `pop` and `tx_valid` both asserted: the write is refused and the count becomes 7.
- Receive filtering with `id`=8'h02:
  - Push 16'h02AA: accepted, `rx_data`=16'h02AA.
  - Push 16'hFF55: accepted.
  - Push 16'h0377: `rx_drop` pulses high and `rx_valid` is unchanged.
- Receive overflow: fill the receive FIFO with 8 packets, then push 16'h0201 twice with `rx_ready`=0.
  - Required: two `rx_drop` pulses and `rx_ovf_cnt`=2 (macro defined).
  - A push while the FIFO is full and `rx_ready`=1 in the same cycle is accepted.
- Reset mid-operation: with 4 packets queued in each FIFO, assert `reset` for 1 cycle while `tx_valid`=1 and `push`=1.
  - Required: `pndng`=0, `rx_valid`=0, `tx_ready`=1, `D_pop`=0 and `rx_ovf_cnt`=0 on the next cycle.

Source files
------------

// File: rtl/bus_port_endpoint.sv
// bus_port_endpoint
//   Terminal-side endpoint for one port of the bs_gnrtr_n_rbtr bus. A transmit
//   FIFO is exposed to the bus via pndng/pop/D_pop. A receive FIFO absorbs bus
//   pushes (push/D_push) whose destination ID matches `id` or `broadcast`. The
//   host reaches both FIFOs through valid/ready handshakes.
//
// Optional feature: define BUS_PORT_OVF_CNT_EN to add rx_ovf_cnt, a saturating
//   count of pushes dropped because the receive FIFO was full.
//
// Ports:
//   clk, reset            : clock; synchronous active-high reset
//   pndng, D_pop, pop     : bus side of the transmit FIFO
//   push, D_push          : bus delivery into the receive FIFO (no backpressure)
//   tx_valid/tx_data/tx_ready : host write into the transmit FIFO
//   rx_valid/rx_data/rx_ready : host read from the receive FIFO
//   rx_drop               : one-cycle pulse per discarded push
//   rx_ovf_cnt            : overflow drop counter (BUS_PORT_OVF_CNT_EN only)
module bus_port_endpoint #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_ready,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic               rx_drop
`ifdef BUS_PORT_OVF_CNT_EN
  ,
  output logic [15:0]        rx_ovf_cnt
`endif
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  // ---------------- transmit FIFO ----------------
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [AW-1:0]      tx_wptr, tx_rptr;
  logic [CW-1:0]      tx_cnt;
  logic               tx_wr, tx_rd;

  // Ready depends on occupancy only, so a full FIFO refuses a write even when
  // the bus pops in the same cycle.
  assign tx_ready = (tx_cnt != FULL_CNT);
  assign pndng    = (tx_cnt != '0);
  assign D_pop    = pndng ? tx_mem[tx_rptr] : '0;
  assign tx_wr    = tx_valid & tx_ready;
  assign tx_rd    = pop & pndng;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
    end else begin
      if (tx_wr) tx_wptr <= tx_wptr + 1'b1;
      if (tx_rd) tx_rptr <= tx_rptr + 1'b1;
      if (tx_wr && !tx_rd)      tx_cnt <= tx_cnt + 1'b1;
      else if (tx_rd && !tx_wr) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && tx_wr) tx_mem[tx_wptr] <= tx_data;
  end

  // ---------------- receive FIFO ----------------
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [AW-1:0]      rx_wptr, rx_rptr;
  logic [CW-1:0]      rx_cnt;
  logic               rx_full, rx_match, rx_wr, rx_rd, rx_ovf;
  logic [7:0]         rx_dest;

  assign rx_dest  = D_push[pckg_sz-1 -: 8];
  assign rx_match = (rx_dest == id) || (rx_dest == broadcast);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_valid = (rx_cnt != '0);
  assign rx_data  = rx_valid ? rx_mem[rx_rptr] : '0;
  assign rx_rd    = rx_ready & rx_valid;
  // When full, a same-cycle host read frees the slot being written: the write
  // pointer equals the read pointer and the head is consumed at this edge.
  assign rx_wr    = push & rx_match & (~rx_full | rx_rd);
  assign rx_ovf   = push & rx_match & rx_full & ~rx_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
      rx_drop <= 1'b0;
    end else begin
      rx_drop <= push & ~rx_wr;
      if (rx_wr) rx_wptr <= rx_wptr + 1'b1;
      if (rx_rd) rx_rptr <= rx_rptr + 1'b1;
      if (rx_wr && !rx_rd)      rx_cnt <= rx_cnt + 1'b1;
      else if (rx_rd && !rx_wr) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rx_wr) rx_mem[rx_wptr] <= D_push;
  end

`ifdef BUS_PORT_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf_cnt <= '0;
    end else if (rx_ovf && rx_ovf_cnt != '1) begin
      rx_ovf_cnt <= rx_ovf_cnt + 1'b1;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = rx_ovf;
`endif

endmodule

// File: tb/tb_bus_port_endpoint.sv
// Directed testbench for bus_port_endpoint (pckg_sz=16, depth=8, id=8'h02).
// rx_ovf_cnt checks are present when BUS_PORT_OVF_CNT_EN is defined.
module tb_bus_port_endpoint;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;
  logic        rx_drop;
`ifdef BUS_PORT_OVF_CNT_EN
  logic [15:0] rx_ovf_cnt;
`endif

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  bus_port_endpoint #(
    .pckg_sz(16),
    .depth(8),
    .id(8'h02),
    .broadcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pndng(pndng),
    .D_pop(D_pop),
    .pop(pop),
    .push(push),
    .D_push(D_push),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .rx_drop(rx_drop)
`ifdef BUS_PORT_OVF_CNT_EN
    ,
    .rx_ovf_cnt(rx_ovf_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [15:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] d);
    push   = 1'b1;
    D_push = d;
    step();
    push   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pop = 1'b0; push = 1'b1; D_push = 16'h02AB;
    tx_valid = 1'b1; tx_data = 16'h1234; rx_ready = 1'b0;
    step();
    step();
    reset = 1'b0; push = 1'b0; tx_valid = 1'b0;
    chk("rst_pndng", 32'(pndng), 32'd0);
    chk("rst_D_pop", 32'(D_pop), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_drop", 32'(rx_drop), 32'd0);
`ifdef BUS_PORT_OVF_CNT_EN
    chk("rst_ovf", 32'(rx_ovf_cnt), 32'd0);
`endif

    // Transmit fill and refused 9th write
    for (int i = 1; i <= 8; i++) begin
      tx_write(16'h0100 + 16'(i));
      chk("fill_pndng", 32'(pndng), 32'd1);
    end
    chk("fill_tx_ready", 32'(tx_ready), 32'd0);
    chk("fill_head", 32'(D_pop), 32'h0101);
    tx_write(16'h0109);
    chk("ninth_head", 32'(D_pop), 32'h0101);
    chk("ninth_tx_ready", 32'(tx_ready), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 32'(D_pop), 32'h0100 + 32'(i));
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    chk("drain_pndng", 32'(pndng), 32'd0);
    chk("drain_D_pop", 32'(D_pop), 32'h0);
    chk("drain_tx_ready", 32'(tx_ready), 32'd1);

    // Pop while empty is ignored
    pop = 1'b1; step(); pop = 1'b0;
    chk("pop_empty_pndng", 32'(pndng), 32'd0);

    // Count 3: write and pop together
    for (int i = 1; i <= 3; i++) tx_write(16'h0A00 + 16'(i));
    tx_valid = 1'b1; tx_data = 16'h0A04; pop = 1'b1;
    step();
    tx_valid = 1'b0; pop = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      chk("simul3_order", 32'(D_pop), 32'h0A00 + 32'(i));
      pop = 1'b1; step(); pop = 1'b0;
    end
    chk("simul3_empty", 32'(pndng), 32'd0);

    // Full: write refused while popping, count becomes 7
    for (int i = 1; i <= 8; i++) tx_write(16'h0B00 + 16'(i));
    tx_valid = 1'b1; tx_data = 16'h0BFF; pop = 1'b1;
    step();
    tx_valid = 1'b0; pop = 1'b0;
    chk("fullpop_tx_ready", 32'(tx_ready), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      chk("fullpop_order", 32'(D_pop), 32'h0B00 + 32'(i));
      pop = 1'b1; step(); pop = 1'b0;
    end
    chk("fullpop_empty", 32'(pndng), 32'd0);

    // Receive filtering
    rx_push(16'h02AA);
    chk("rx_own_valid", 32'(rx_valid), 32'd1);
    chk("rx_own_data", 32'(rx_data), 32'h02AA);
    chk("rx_own_drop", 32'(rx_drop), 32'd0);
    rx_push(16'hFF55);
    chk("rx_bcast_drop", 32'(rx_drop), 32'd0);
    rx_push(16'h0377);
    chk("rx_mis_drop", 32'(rx_drop), 32'd1);
    chk("rx_mis_valid", 32'(rx_valid), 32'd1);
    chk("rx_mis_head", 32'(rx_data), 32'h02AA);
    step();
    chk("rx_drop_pulse", 32'(rx_drop), 32'd0);
`ifdef BUS_PORT_OVF_CNT_EN
    chk("rx_mis_ovf", 32'(rx_ovf_cnt), 32'd0);
`endif
    rx_ready = 1'b1;
    step();
    chk("rx_read_bcast", 32'(rx_data), 32'hFF55);
    step();
    chk("rx_read_empty_v", 32'(rx_valid), 32'd0);
    chk("rx_read_empty_d", 32'(rx_data), 32'h0);
    step();
    chk("rx_ready_empty", 32'(rx_valid), 32'd0);
    rx_ready = 1'b0;

    // Receive overflow
    for (int i = 1; i <= 8; i++) rx_push(16'h0210 + 16'(i));
    rx_push(16'h0201);
    chk("ovf_drop1", 32'(rx_drop), 32'd1);
    rx_push(16'h0201);
    chk("ovf_drop2", 32'(rx_drop), 32'd1);
`ifdef BUS_PORT_OVF_CNT_EN
    chk("ovf_cnt2", 32'(rx_ovf_cnt), 32'd2);
`endif
    push = 1'b1; D_push = 16'h02EE; rx_ready = 1'b1;
    step();
    push = 1'b0; rx_ready = 1'b0;
    chk("ovf_rd_accept", 32'(rx_drop), 32'd0);
    chk("ovf_rd_head", 32'(rx_data), 32'h0212);
`ifdef BUS_PORT_OVF_CNT_EN
    chk("ovf_rd_cnt", 32'(rx_ovf_cnt), 32'd2);
`endif
    for (int i = 2; i <= 8; i++) begin
      chk("ovf_order", 32'(rx_data), 32'h0210 + 32'(i));
      rx_ready = 1'b1; step(); rx_ready = 1'b0;
    end
    chk("ovf_last", 32'(rx_data), 32'h02EE);
    rx_ready = 1'b1; step(); rx_ready = 1'b0;
    chk("ovf_empty", 32'(rx_valid), 32'd0);

    // Reset mid-operation with 4 queued in each FIFO
    for (int i = 1; i <= 4; i++) begin
      tx_write(16'h0C00 + 16'(i));
      rx_push(16'h0230 + 16'(i));
    end
    reset = 1'b1; tx_valid = 1'b1; tx_data = 16'h0CFF;
    push = 1'b1; D_push = 16'h02CC;
    step();
    reset = 1'b0; tx_valid = 1'b0; push = 1'b0;
    chk("mid_pndng", 32'(pndng), 32'd0);
    chk("mid_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_D_pop", 32'(D_pop), 32'h0);
    chk("mid_rx_drop", 32'(rx_drop), 32'd0);
`ifdef BUS_PORT_OVF_CNT_EN
    chk("mid_ovf", 32'(rx_ovf_cnt), 32'd0);
`endif
    tx_write(16'h0D01);
    chk("post_rst_tx", 32'(D_pop), 32'h0D01);
    rx_push(16'h02D2);
    chk("post_rst_rx", 32'(rx_data), 32'h02D2);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
